lfsr_checker: RTL
=================

LFSR_CHECKER -- requirements
Module: lfsr_checker

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, giving the word width of the checked LFSR stream.
REQ-002 SHALL have parameter LOCK_CNT, default 4, giving the consecutive matching words needed to enter LOCKED.
REQ-003 SHALL have parameter ERR_LIMIT, default 3, giving the consecutive mismatching words in LOCKED that force HUNT.
REQ-004 SHALL have parameter CNT_WIDTH, default 16, giving the error counter width.
REQ-005 SHALL have parameter DEFAULT_TAP, default 8'hB8, giving the tap register reset value.
REQ-006 SHALL have port clk, input, 1 bit: single clock; all state updates on posedge.
REQ-007 SHALL have port resetn, input, 1 bit: asynchronous, active-low reset.
REQ-008 SHALL have port din, input, DATA_WIDTH bits: received LFSR word, one per valid cycle.
REQ-009 SHALL have port din_valid, input, 1 bit: din is qualified this cycle.
REQ-010 SHALL have port tap, input, DATA_WIDTH bits: feedback polynomial, latched only on clr.
REQ-011 SHALL have port clr, input, 1 bit: synchronous restart pulse.
REQ-012 SHALL have port locked, output, 1 bit: high while the FSM is in LOCKED.
REQ-013 SHALL have port err_pulse, output, 1 bit: one-cycle flag for a mismatch while LOCKED.
REQ-014 SHALL have port err_cnt, output, CNT_WIDTH bits: saturating count of mismatches while LOCKED.

Function
REQ-015 Step function SHALL be step(x) = {^(x & tap_q), x[DATA_WIDTH-1:1]}, i.e. right shift with the parity of tapped bits inserted at the MSB.
REQ-016 FSM SHALL have exactly two states, HUNT and LOCKED, with state, exp, have_prev, good_cnt, bad_cnt and tap_q held in registers.
REQ-017 Cycles with din_valid=0 SHALL change no state or counter, and err_pulse SHALL be 0 in those cycles.
REQ-018 In HUNT with a valid word, exp SHALL load step(din) and have_prev SHALL be set.
REQ-019 A HUNT match SHALL be have_prev=1, din==exp and din!=0; a match increments good_cnt, anything else clears it.
REQ-020 An all-zero din SHALL never count as a match, so the checker cannot lock onto a dead stream.
REQ-021 On the match that brings good_cnt to LOCK_CNT, the state SHALL become LOCKED, locked SHALL read 1 from the next cycle, and good_cnt SHALL clear.
REQ-022 In LOCKED with a valid word, exp SHALL load step(exp), free-running and not reseeded from din.
REQ-023 A LOCKED mismatch (din!=exp) SHALL assert err_pulse for one cycle, registered and visible the cycle after the din sample.
REQ-024 A LOCKED mismatch SHALL increment err_cnt, saturating at all-ones, and SHALL increment bad_cnt.
REQ-025 A LOCKED match SHALL clear bad_cnt.
REQ-026 When bad_cnt reaches ERR_LIMIT, the state SHALL return to HUNT, bad_cnt and have_prev SHALL clear, and err_cnt SHALL hold its value.
REQ-027 On clr=1, tap_q SHALL load tap, state SHALL go to HUNT, all counters including err_cnt SHALL clear, and have_prev SHALL clear.
REQ-028 clr SHALL take priority over a coincident din_valid, and that word SHALL be discarded.

Reset
REQ-029 On resetn=0, asynchronously: state=HUNT, tap_q=DEFAULT_TAP, exp=0, have_prev=0, good_cnt=0, bad_cnt=0.
REQ-030 On resetn=0, asynchronously: locked=0, err_pulse=0, err_cnt=0.
REQ-031 Reset mid-stream SHALL abandon lock immediately, with outputs taking reset values without waiting for a clock edge.
REQ-032 Reset deassertion SHALL be synchronised externally, and the block SHALL add no synchroniser.

Structure
REQ-033 Shared package lfsr_pkg SHALL hold the state enum typedef (HUNT, LOCKED) and the lfsr_step function, so the generator and checker share one definition.
REQ-034 No sub-module is required; one always_ff for state and counters plus a combinational next-expected term SHALL suffice.

Verification
REQ-035 Lock: after clr with tap=8'hB8, feed the clean stream seeded 8'hE1 (E1, 70, 38, ...) every cycle -> locked=1 after the 5th valid word (4 matches), err_cnt=0.
REQ-036 Single error: while locked, flip bit 0 of one word -> one err_pulse, err_cnt=1, locked stays 1, the next clean words match because exp is not reseeded.
REQ-037 Loss of lock: while locked, corrupt 3 consecutive words -> err_cnt=3, locked=0 the cycle after the 3rd error, and relock after 5 further clean words.
REQ-038 Zero stream: after clr, feed din=8'h00 for 20 valid cycles -> locked stays 0, err_cnt=0.
REQ-039 Gaps and clr: a locked stream with din_valid toggled 0/1 -> no false errors; clr together with a corrupted valid word -> err_cnt=0, state HUNT, no err_pulse.
REQ-040 Async reset and saturation: with CNT_WIDTH=4, force 20 errors, repeatedly relocking after each loss -> err_cnt=4'hF; resetn low mid-cycle -> locked and err_cnt clear before the next clk edge.

Source files
------------

// File: rtl/lfsr_pkg.sv
// Shared LFSR definitions: checker state encoding and the step function
// used by both the stream generator and the checker.
package lfsr_pkg;

    typedef enum logic [0:0] {
        HUNT   = 1'b0,
        LOCKED = 1'b1
    } lfsr_state_e;

    localparam int unsigned LFSR_MAX_W = 64;

    // One LFSR step on a word zero-extended to LFSR_MAX_W: right shift with
    // the parity of the tapped bits inserted at bit (width-1).
    function automatic logic [LFSR_MAX_W-1:0] lfsr_step(
        input logic [LFSR_MAX_W-1:0] x,
        input logic [LFSR_MAX_W-1:0] tap,
        input int unsigned           width
    );
        logic                  par;
        logic [LFSR_MAX_W-1:0] res;
        par = ^(x & tap);
        res = (x >> 1) | ({{(LFSR_MAX_W-1){1'b0}}, par} << (width - 32'd1));
        return res;
    endfunction

endpackage

// File: rtl/lfsr_checker.sv
// LFSR stream checker: hunts for lock on a received LFSR word stream, then
// free-runs its own expected sequence and counts mismatches while locked.
module lfsr_checker
    import lfsr_pkg::*;
#(
    parameter int unsigned          DATA_WIDTH  = 8,
    parameter int unsigned          LOCK_CNT    = 4,
    parameter int unsigned          ERR_LIMIT   = 3,
    parameter int unsigned          CNT_WIDTH   = 16,
    parameter logic [DATA_WIDTH-1:0] DEFAULT_TAP = 8'hB8
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic [DATA_WIDTH-1:0] din,
    input  logic                  din_valid,
    input  logic [DATA_WIDTH-1:0] tap,
    input  logic                  clr,
    output logic                  locked,
    output logic                  err_pulse,
    output logic [CNT_WIDTH-1:0]  err_cnt
);

    localparam int unsigned GOOD_W = $clog2(LOCK_CNT + 1);
    localparam int unsigned BAD_W  = $clog2(ERR_LIMIT + 1);

    lfsr_state_e           state_r, state_next_s;
    logic [DATA_WIDTH-1:0] exp_r, exp_next_s;
    logic [DATA_WIDTH-1:0] tap_r, tap_next_s;
    logic                  have_prev_r, have_prev_next_s;
    logic [GOOD_W-1:0]     good_r, good_next_s, good_inc_s;
    logic [BAD_W-1:0]      bad_r, bad_next_s, bad_inc_s;
    logic [CNT_WIDTH-1:0]  err_cnt_r, err_cnt_next_s;
    logic                  err_pulse_r, err_pulse_next_s;
    logic                  locked_r;

    logic [DATA_WIDTH-1:0] step_src_s, step_s;
    logic [LFSR_MAX_W-1:0] step_full_s;
    logic                  hunt_match_s;

    // While locked the expectation free-runs from itself; in HUNT it is reseeded from din.
    assign step_src_s   = (state_r == LOCKED) ? exp_r : din;
    assign step_full_s  = lfsr_step(LFSR_MAX_W'(step_src_s), LFSR_MAX_W'(tap_r), DATA_WIDTH);
    assign step_s       = step_full_s[DATA_WIDTH-1:0];
    assign hunt_match_s = have_prev_r && (din == exp_r) && (din != {DATA_WIDTH{1'b0}});
    assign good_inc_s   = good_r + GOOD_W'(1);
    assign bad_inc_s    = bad_r + BAD_W'(1);

    // Next-state, counter and error-flag computation.
    always_comb begin
        state_next_s     = state_r;
        exp_next_s       = exp_r;
        tap_next_s       = tap_r;
        have_prev_next_s = have_prev_r;
        good_next_s      = good_r;
        bad_next_s       = bad_r;
        err_cnt_next_s   = err_cnt_r;
        err_pulse_next_s = 1'b0;

        if (clr) begin
            tap_next_s       = tap;
            state_next_s     = HUNT;
            have_prev_next_s = 1'b0;
            good_next_s      = {GOOD_W{1'b0}};
            bad_next_s       = {BAD_W{1'b0}};
            err_cnt_next_s   = {CNT_WIDTH{1'b0}};
        end else if (din_valid) begin
            exp_next_s = step_s;
            case (state_r)
                HUNT: begin
                    have_prev_next_s = 1'b1;
                    if (hunt_match_s) begin
                        if (good_inc_s == GOOD_W'(LOCK_CNT)) begin
                            state_next_s = LOCKED;
                            good_next_s  = {GOOD_W{1'b0}};
                        end else begin
                            good_next_s  = good_inc_s;
                        end
                    end else begin
                        good_next_s = {GOOD_W{1'b0}};
                    end
                end
                LOCKED: begin
                    if (din != exp_r) begin
                        err_pulse_next_s = 1'b1;
                        if (err_cnt_r != {CNT_WIDTH{1'b1}}) begin
                            err_cnt_next_s = err_cnt_r + CNT_WIDTH'(1);
                        end else begin
                            err_cnt_next_s = err_cnt_r;
                        end
                        // Too many consecutive misses: drop lock and start hunting afresh.
                        if (bad_inc_s == BAD_W'(ERR_LIMIT)) begin
                            state_next_s     = HUNT;
                            bad_next_s       = {BAD_W{1'b0}};
                            have_prev_next_s = 1'b0;
                        end else begin
                            bad_next_s       = bad_inc_s;
                        end
                    end else begin
                        bad_next_s = {BAD_W{1'b0}};
                    end
                end
                default: begin
                    state_next_s     = HUNT;
                    have_prev_next_s = 1'b0;
                    good_next_s      = {GOOD_W{1'b0}};
                    bad_next_s       = {BAD_W{1'b0}};
                end
            endcase
        end else begin
            err_pulse_next_s = 1'b0;
        end
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_r     <= HUNT;
            exp_r       <= {DATA_WIDTH{1'b0}};
            tap_r       <= DEFAULT_TAP;
            have_prev_r <= 1'b0;
            good_r      <= {GOOD_W{1'b0}};
            bad_r       <= {BAD_W{1'b0}};
            err_cnt_r   <= {CNT_WIDTH{1'b0}};
            err_pulse_r <= 1'b0;
            locked_r    <= 1'b0;
        end else begin
            state_r     <= state_next_s;
            exp_r       <= exp_next_s;
            tap_r       <= tap_next_s;
            have_prev_r <= have_prev_next_s;
            good_r      <= good_next_s;
            bad_r       <= bad_next_s;
            err_cnt_r   <= err_cnt_next_s;
            err_pulse_r <= err_pulse_next_s;
            locked_r    <= (state_next_s == LOCKED);
        end
    end

    assign locked    = locked_r;
    assign err_pulse = err_pulse_r;
    assign err_cnt   = err_cnt_r;

endmodule
